// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: opcode constants, field widths and
// the FSM state encoding used by the top level.
package alu_pkg;

    localparam int OP_W  = 3;
    localparam int TAG_W = 4;

    localparam logic [OP_W-1:0] OP_ZERO = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
    localparam logic [OP_W-1:0] OP_NOTB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; pushes into a full FIFO and
// pops from an empty one are ignored. Read data is the current head entry.
module alu_cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != FULL);
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // alone decide which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_driver.sv
// Command initiator for the combinational ALU: queues commands, issues them
// one at a time on registered lines and returns each result with its tag.
module alu_driver
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [W-1:0]               cmd_a,
    input  logic [W-1:0]               cmd_b,
    input  logic [OP_W-1:0]            cmd_op,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    output logic [OP_W-1:0]            alu_opcode,
    input  logic [2*W-1:0]             alu_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2*W-1:0]             rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_zero,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CMD_W = 2*W + OP_W + TAG_W;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t             state;
    state_t             next_state;
    logic               pop;
    logic [CMD_W-1:0]   head;
    logic [TAG_W-1:0]   cur_tag;

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens a slot in a full FIFO.
    assign cmd_ready = (count != FULL);
    assign rsp_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE) || (count != '0);

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_a, cmd_b, cmd_op, cmd_tag}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: next_state = S_HOLD;
            S_HOLD: begin
                if (rsp_ready) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        next_state = S_ISSUE;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            cur_tag    <= '0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (pop) {alu_a, alu_b, alu_opcode, cur_tag} <= head;
            // ISSUE gave the ALU a full cycle to settle on the new operands.
            if (state == S_ISSUE) begin
                rsp_data <= alu_out;
                rsp_zero <= (alu_out == '0);
                rsp_tag  <= cur_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: a behavioural ALU closes the loop, and a
// vector table plus hand-written sequences cover latency, ordering and reset.
module tb_alu_driver;
    import alu_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_tag;
    logic       rsp_zero;
    logic       busy;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_driver #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero),
        .busy(busy), .count(count)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (op)
            3'b000:  return 8'h00;
            3'b001:  return ea + eb;
            3'b010:  return ea - eb;
            3'b011:  return ea * eb;
            3'b100:  return ea & eb;
            3'b101:  return ea | eb;
            3'b110:  return ~ea;
            default: return ~eb;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_a, alu_b, alu_opcode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input int max_cyc, output bit ok);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                @(posedge clk); @(negedge clk);
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it, and completes the handshake.
    task automatic collect(input logic [3:0] tag, input logic [7:0] data, input string name);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check({name, "_valid"}, rsp_valid, 1);
        check({name, "_tag"}, rsp_tag, tag);
        check({name, "_data"}, rsp_data, data);
        if (rsp_valid) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [2:0] op;
        logic [3:0] tag;
        logic [7:0] exp;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat, accepted, nvalid;
        logic       tp_valid[8];
        logic [2:0] tp_op[8];
        logic [3:0] tp_tag[8];
        logic [7:0] tp_data[8];

        vecs[0] = '{4'h3, 4'h5, OP_ADD,  4'h1, 8'h08, 1'b0};
        vecs[1] = '{4'h3, 4'h5, OP_SUB,  4'h2, 8'hFE, 1'b0};
        vecs[2] = '{4'hF, 4'hF, OP_MUL,  4'h3, 8'hE1, 1'b0};
        vecs[3] = '{4'h0, 4'h7, OP_NOTA, 4'h4, 8'hFF, 1'b0};
        vecs[4] = '{4'h7, 4'h9, OP_ZERO, 4'h5, 8'h00, 1'b1};
        vecs[5] = '{4'hC, 4'hA, OP_AND,  4'h6, 8'h08, 1'b0};
        vecs[6] = '{4'hC, 4'hA, OP_OR,   4'h7, 8'h0E, 1'b0};
        vecs[7] = '{4'h9, 4'h5, OP_NOTB, 4'h8, 8'hFA, 1'b0};
        vecs[8] = '{4'h5, 4'h5, OP_SUB,  4'h9, 8'h00, 1'b1};
        vecs[9] = '{4'hF, 4'h1, OP_ADD,  4'hA, 8'h10, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        #3;
        check("reset_alu_regs", {alu_a, alu_b, alu_opcode}, 0);
        check("reset_rsp", {rsp_valid, rsp_data, rsp_tag, rsp_zero}, 0);
        check("reset_count_busy", {count, busy}, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Single commands: latency counted from the acceptance edge.
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, 5, ok);
            check("vec_accept", ok, 1);
            lat = 1;
            while (!rsp_valid && lat < 10) begin
                @(posedge clk); @(negedge clk);
                lat++;
            end
            check("vec_latency", lat, 3);
            check("vec_data", rsp_data, vecs[i].exp);
            check("vec_tag", rsp_tag, vecs[i].tag);
            check("vec_zero", rsp_zero, vecs[i].exp_zero);
            @(posedge clk); @(negedge clk);
        end
        check("vec_idle_busy", busy, 0);

        // Back-pressure: one command parks in HOLD, four more fill the FIFO.
        rsp_ready = 1'b0;
        accepted = 0;
        for (int t = 0; t < 6; t++) begin
            push(4'(t), 4'h1, OP_ADD, 4'(t), 4, ok);
            if (ok) accepted++;
        end
        check("bp_accepted", accepted, 5);
        check("bp_count", count, 4);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_hold_valid", rsp_valid, 1);
        check("bp_hold_tag", rsp_tag, 0);
        rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) collect(4'(t), 8'(t + 1), "bp_rsp");
        check("bp_drained_busy", busy, 0);

        // Throughput: HOLD -> ISSUE -> HOLD with rsp_ready held high.
        rsp_ready = 1'b0;
        push(4'h3, 4'h5, OP_ADD, 4'h8, 4, ok);
        push(4'h3, 4'h5, OP_SUB, 4'h9, 4, ok);
        push(4'h2, 4'h3, OP_MUL, 4'hA, 4, ok);
        push(4'h6, 4'h3, OP_AND, 4'hB, 4, ok);
        tp_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tp_op    = '{OP_ADD, OP_SUB, OP_SUB, OP_MUL, OP_MUL, OP_AND, OP_AND, OP_AND};
        tp_tag   = '{4'h8, 4'h0, 4'h9, 4'h0, 4'hA, 4'h0, 4'hB, 4'h0};
        tp_data  = '{8'h08, 8'h00, 8'hFE, 8'h00, 8'h06, 8'h00, 8'h02, 8'h00};
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("tp_valid", rsp_valid, tp_valid[k]);
            check("tp_opcode", alu_opcode, tp_op[k]);
            if (tp_valid[k]) begin
                check("tp_tag", rsp_tag, tp_tag[k]);
                check("tp_data", rsp_data, tp_data[k]);
            end
            @(posedge clk); @(negedge clk);
        end
        check("tp_idle_busy", busy, 0);

        // Reset in HOLD with two commands still queued.
        rsp_ready = 1'b0;
        push(4'h1, 4'h1, OP_ADD, 4'h1, 4, ok);
        push(4'h1, 4'h1, OP_ADD, 4'h2, 4, ok);
        push(4'h1, 4'h1, OP_ADD, 4'h3, 4, ok);
        check("rst_pre_count", count, 2);
        check("rst_pre_valid", rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_alu_regs", {alu_a, alu_b, alu_opcode}, 0);
        check("rst_mid_rsp", {rsp_valid, rsp_data, rsp_tag, rsp_zero}, 0);
        check("rst_mid_count_busy", {count, busy}, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid || busy) nvalid++;
        end
        check("rst_after_quiet", nvalid, 0);

        // Simultaneous push and pop while two commands are queued.
        rsp_ready = 1'b0;
        push(4'h2, 4'h3, OP_ADD, 4'h1, 4, ok);
        push(4'h9, 4'h6, OP_OR,  4'h2, 4, ok);
        push(4'h3, 4'h3, OP_MUL, 4'h3, 4, ok);
        check("pp_pre_count", count, 2);
        check("pp_hold_tag", rsp_tag, 1);
        check("pp_hold_data", rsp_data, 8'h05);
        check("pp_cmd_ready", cmd_ready, 1);
        cmd_a = 4'hC; cmd_b = 4'h5; cmd_op = OP_AND; cmd_tag = 4'h4;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        check("pp_count", count, 2);
        check("pp_issue_valid", rsp_valid, 0);
        collect(4'h2, 8'h0F, "pp_rsp");
        collect(4'h3, 8'h09, "pp_rsp");
        collect(4'h4, 8'h04, "pp_rsp");
        check("pp_final_count_busy", {count, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
